timer_cfg: RTL and testbench
============================

# timer_cfg

Configuration and status stage placed directly upstream of the `timer` block. It captures CPU output writes to I/O port 4 and splits the byte into the timer's outputs: bits 7:2 become `umbral`, bits 1:0 become `basetiempo`. It issues a one-cycle restart pulse to the timer on every valid write. It edge-detects `timer_end` into a sticky, read-to-clear interrupt/status register that the CPU reads back on the same port.

## Interface
Parameters:
- `ADDR_W`, 3: width of the CPU I/O port address.
- `TIMER_PORT`, 3'd4: port address that this block decodes, for both writes and reads.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `we_out`, in, 1: CPU output-write strobe, one cycle.
- `dir_out`, in, ADDR_W: output port address.
- `dato_out`, in, 8: output data. Bits 7:2 are the threshold; bits 1:0 are the time base.
- `re_in`, in, 1: CPU input-read strobe, one cycle.
- `dir_in`, in, ADDR_W: input port address.
- `dato_in`, out, 8: read data, combinational.
- `timer_end`, in, 1: expiry signal from the timer; a level or pulse in the `clk` domain.
- `umbral`, out, 6: registered threshold to the timer.
- `basetiempo`, out, 2: registered time base to the timer.
- `timer_rst`, out, 1: restart pulse to the timer, active high, exactly one cycle.
- `irq`, out, 1: sticky expiry flag.

## Operation
- **Write hit:** `we_out && dir_out == TIMER_PORT`.
- **Read hit:** `re_in && dir_in == TIMER_PORT`.
- **Internal registers:**
  - `state`: IDLE, RUNNING or EXPIRED.
  - `cnt[3:0]`: expiries since the last read, saturating at 15.
  - `ovf`: set by an expiry while `irq` is already 1.
  - `te_q`: previous value of `timer_end`.
- **Expiry event:** `timer_end && !te_q && state != IDLE && !timer_rst && !write hit`.
- **Write hit with `dato_out != 0`:**
  - Latch `umbral = dato_out[7:2]` and `basetiempo = dato_out[1:0]`.
  - Assert `timer_rst` on the next cycle.
  - Clear `irq`, `ovf` and `cnt`.
  - `state` becomes RUNNING.
- **Write hit with `dato_out == 0`:**
  - Disables the timer: `umbral` and `basetiempo` become 0, no `timer_rst` pulse.
  - Clear `irq`, `ovf` and `cnt`.
  - `state` becomes IDLE.
- **Expiry event (RUNNING or EXPIRED):**
  - `irq` becomes 1.
  - `cnt` becomes `min(cnt+1, 15)`.
  - `ovf` is set if `irq` was already 1.
  - `state` becomes EXPIRED.
- **Read hit:**
  - `dato_in = {irq, ovf, state==IDLE ? 1'b0 : 1'b1, 1'b0, cnt}`.
  - Otherwise `dato_in = 8'h00`.
  - On the clock edge, `irq`, `ovf` and `cnt` clear, and EXPIRED returns to RUNNING.
- **Periodic timer:** the timer keeps running after expiry. The block never stops it except via a zero write.
- **State transitions:**
  - IDLE → RUNNING on a non-zero write.
  - RUNNING → EXPIRED on expiry.
  - EXPIRED → RUNNING on a read.
  - Any state → IDLE on a zero write.
  - Any state → RUNNING on a non-zero write.
- **Priority, highest first:** reset, write hit, expiry, read clear.
- **Read and expiry in the same cycle:** the old values are returned on `dato_in`. After the edge, `irq=1`, `cnt=1`, `ovf=0`.
- **Write and expiry in the same cycle:** the expiry is dropped.

## Timing
- **Reset (asynchronous, while `reset` = 0):** `umbral=0`, `basetiempo=0`, `timer_rst=0`, `irq=0`, `cnt=0`, `ovf=0`, `te_q=0`, `state=IDLE`. `dato_in` follows its combinational rule.
- **Reset mid-operation:** all registers clear immediately. No `timer_rst` pulse is generated on release.
- **Write to outputs:** write hit in cycle N gives `umbral`/`basetiempo` valid and `timer_rst=1` in cycle N+1. `timer_rst` returns to 0 in N+2.
- **Back-to-back writes:** writes in N and N+1 give `timer_rst` high in N+1 and N+2. The configuration from the last write is held.
- **Expiry latency:** a `timer_end` rising edge sampled at edge N gives `irq=1` after edge N.
  - A level held high counts once.
  - A new event requires `timer_end` to go low for at least one cycle.
- **Masking:** events are ignored during the `timer_rst` cycle and the write-hit cycle.
- **Read data:** `dato_in` is valid in the same cycle as `re_in`. The clear takes effect after that edge.
- **Saturation:** at `cnt=15`, further expiries keep `cnt` at 15 and keep `ovf=1`.

## Test plan
- **Reset:** assert `reset=0` mid-run with `irq=1` → all outputs 0 immediately. Release, then 10 cycles of `timer_end` pulses → `irq` stays 0 (IDLE).
- **Configure:** write `8'hB6` to port 4 → next cycle `umbral=6'h2D`, `basetiempo=2'b10`, `timer_rst=1` for exactly one cycle. A write to port 3 → no change.
- **Expiry and read-clear:** after configuring, one `timer_end` pulse → `irq=1`. Read port 4 → `dato_in=8'hA1`; the next cycle `irq=0`, and a second read gives `8'h20`.
- **Overflow and saturation:** 17 `timer_end` pulses without a read → `dato_in=8'hEF` (`irq=1`, `ovf=1`, `cnt=15`).
- **Simultaneous events:**
  - Read and `timer_end` edge in the same cycle → read returns the old status; afterwards `irq=1`, `cnt=1`.
  - Write and `timer_end` edge in the same cycle → `irq=0`, `cnt=0`.
- **Disable:** write `8'h00` → `umbral=0`, `basetiempo=0`, no `timer_rst`, `irq` cleared. Subsequent `timer_end` edges → ignored; read returns `8'h00`.

Source files
------------

// File: rtl/timer_cfg.sv
// timer_cfg: decodes CPU port writes into timer threshold/time base and
// keeps a sticky, read-to-clear expiry status for the CPU.
module timer_cfg #(
  parameter int unsigned          ADDR_W     = 3,
  parameter logic [ADDR_W-1:0]    TIMER_PORT = 3'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_out,
  input  logic [ADDR_W-1:0] dir_out,
  input  logic [7:0]        dato_out,
  input  logic              re_in,
  input  logic [ADDR_W-1:0] dir_in,
  output logic [7:0]        dato_in,
  input  logic              timer_end,
  output logic [5:0]        umbral,
  output logic [1:0]        basetiempo,
  output logic              timer_rst,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    EXPIRED
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  umb_q, umb_d;
  logic [1:0]  base_q, base_d;
  logic        trst_q, trst_d;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        te_q;

  logic wr_hit;
  logic rd_hit;
  logic expiry;

  assign wr_hit = we_out && (dir_out == TIMER_PORT);
  assign rd_hit = re_in && (dir_in == TIMER_PORT);
  assign expiry = timer_end && !te_q && (state_q != IDLE)
                  && !trst_q && !wr_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      umb_q   <= '0;
      base_q  <= '0;
      trst_q  <= 1'b0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      umb_q   <= umb_d;
      base_q  <= base_d;
      trst_q  <= trst_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      te_q    <= timer_end;
    end
  end

  // Read clear is applied first so a same-cycle expiry lands on clean status.
  always_comb begin
    state_d = state_q;
    umb_d   = umb_q;
    base_d  = base_q;
    trst_d  = 1'b0;
    irq_d   = irq_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (wr_hit) begin
      irq_d = 1'b0;
      ovf_d = 1'b0;
      cnt_d = '0;
      if (dato_out != 8'h00) begin
        umb_d   = dato_out[7:2];
        base_d  = dato_out[1:0];
        trst_d  = 1'b1;
        state_d = RUNNING;
      end else begin
        umb_d   = '0;
        base_d  = '0;
        state_d = IDLE;
      end
    end else begin
      if (rd_hit) begin
        irq_d = 1'b0;
        ovf_d = 1'b0;
        cnt_d = '0;
        if (state_q == EXPIRED) state_d = RUNNING;
      end
      if (expiry) begin
        ovf_d   = ovf_d | irq_d;
        irq_d   = 1'b1;
        cnt_d   = (cnt_d == 4'hF) ? 4'hF : cnt_d + 4'd1;
        state_d = EXPIRED;
      end
    end
  end

  always_comb begin
    dato_in = 8'h00;
    if (rd_hit) begin
      dato_in = {irq_q, ovf_q, (state_q != IDLE), 1'b0, cnt_q};
    end
  end

  assign umbral     = umb_q;
  assign basetiempo = base_q;
  assign timer_rst  = trst_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_timer_cfg.sv
// tb_timer_cfg: vector table plus hand sequences for timer_cfg,
// expected results queued at drive time and checked after the edge.
module tb_timer_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       we_out;
  logic [2:0] dir_out;
  logic [7:0] dato_out;
  logic       re_in;
  logic [2:0] dir_in;
  logic [7:0] dato_in;
  logic       timer_end;
  logic [5:0] umbral;
  logic [1:0] basetiempo;
  logic       timer_rst;
  logic       irq;

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic       we;
    logic [2:0] dout_a;
    logic [7:0] dout;
    logic       re;
    logic [2:0] din_a;
    logic       te;
    logic [7:0] e_din;
    logic [5:0] e_umb;
    logic [1:0] e_base;
    logic       e_trst;
    logic       e_irq;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[23];

  timer_cfg dut (
    .clk(clk), .reset(reset),
    .we_out(we_out), .dir_out(dir_out), .dato_out(dato_out),
    .re_in(re_in), .dir_in(dir_in), .dato_in(dato_in),
    .timer_end(timer_end), .umbral(umbral),
    .basetiempo(basetiempo), .timer_rst(timer_rst), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic we, logic [2:0] oa, logic [7:0] d,
    logic re, logic [2:0] ia, logic te,
    logic [7:0] edin, logic [5:0] eu, logic [1:0] eb,
    logic et, logic ei);
    vec_t v;
    v.we = we; v.dout_a = oa; v.dout = d;
    v.re = re; v.din_a = ia; v.te = te;
    v.e_din = edin; v.e_umb = eu; v.e_base = eb;
    v.e_trst = et; v.e_irq = ei;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(vec_t v, string nm);
    vec_t e;
    @(negedge clk);
    we_out = v.we; dir_out = v.dout_a; dato_out = v.dout;
    re_in = v.re; dir_in = v.din_a; timer_end = v.te;
    sb_q.push_back(v);
    #1;
    chk({nm, ".dato_in"}, dato_in, v.e_din);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({nm, ".umbral"}, {2'b0, umbral}, {2'b0, e.e_umb});
    chk({nm, ".base"}, {6'b0, basetiempo}, {6'b0, e.e_base});
    chk({nm, ".trst"}, {7'b0, timer_rst}, {7'b0, e.e_trst});
    chk({nm, ".irq"}, {7'b0, irq}, {7'b0, e.e_irq});
  endtask

  initial begin
    reset = 1'b0;
    we_out = 0; dir_out = 0; dato_out = 0;
    re_in = 0; dir_in = 0; timer_end = 0;

    //            we oa  data  re ia  te  din    umb    b   tr ir
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h00, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[2]  = mk(1, 3, 8'hB6, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[3]  = mk(1, 4, 8'hB6, 0, 0, 0, 8'h00, 6'h2D, 2, 1, 0);
    tbl[4]  = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h2D, 2, 0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h2D, 2, 0, 1);
    tbl[6]  = mk(0, 0, 8'h00, 1, 4, 0, 8'hA1, 6'h2D, 2, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 4, 0, 8'h20, 6'h2D, 2, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 4, 1, 8'h20, 6'h2D, 2, 0, 1);
    tbl[9]  = mk(0, 0, 8'h00, 1, 4, 0, 8'hA1, 6'h2D, 2, 0, 0);
    tbl[10] = mk(1, 4, 8'hB6, 0, 0, 1, 8'h00, 6'h2D, 2, 1, 0);
    tbl[11] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h2D, 2, 0, 0);
    tbl[12] = mk(0, 0, 8'h00, 1, 4, 0, 8'h20, 6'h2D, 2, 0, 0);
    tbl[13] = mk(1, 4, 8'h55, 0, 0, 0, 8'h00, 6'h15, 1, 1, 0);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h15, 1, 0, 0);
    tbl[15] = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h15, 1, 0, 0);
    tbl[16] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h15, 1, 0, 0);
    tbl[17] = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h15, 1, 0, 1);
    tbl[18] = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h15, 1, 0, 1);
    tbl[19] = mk(0, 0, 8'h00, 1, 4, 0, 8'hA1, 6'h15, 1, 0, 0);
    tbl[20] = mk(1, 4, 8'h00, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[21] = mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h00, 0, 0, 0);
    tbl[22] = mk(0, 0, 8'h00, 1, 4, 0, 8'h00, 6'h00, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    re_in = 1; dir_in = 4;
    #1;
    chk("rst.dato_in", dato_in, 8'h00);
    chk("rst.umbral", {2'b0, umbral}, 8'h00);
    chk("rst.trst", {7'b0, timer_rst}, 8'h00);
    chk("rst.irq", {7'b0, irq}, 8'h00);
    re_in = 0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i], $sformatf("v%0d", i));
    end

    step(mk(1, 4, 8'hB6, 0, 0, 0, 8'h00, 6'h2D, 2, 1, 0), "cfg");
    step(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h2D, 2, 0, 0), "cfg2");
    for (int i = 0; i < 17; i++) begin
      step(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h2D, 2, 0, 1),
           $sformatf("sat%0d_hi", i));
      step(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h2D, 2, 0, 1),
           $sformatf("sat%0d_lo", i));
    end
    step(mk(0, 0, 8'h00, 1, 3, 0, 8'h00, 6'h2D, 2, 0, 1), "rdp3");
    step(mk(0, 0, 8'h00, 1, 4, 0, 8'hEF, 6'h2D, 2, 0, 0), "sat_rd");
    step(mk(0, 0, 8'h00, 1, 4, 0, 8'h20, 6'h2D, 2, 0, 0), "sat_rd2");
    step(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h2D, 2, 0, 1), "pre_rst");

    @(negedge clk);
    timer_end = 0;
    reset = 1'b0;
    #1;
    chk("mrst.umbral", {2'b0, umbral}, 8'h00);
    chk("mrst.base", {6'b0, basetiempo}, 8'h00);
    chk("mrst.trst", {7'b0, timer_rst}, 8'h00);
    chk("mrst.irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 6'h00, 0, 0, 0),
           $sformatf("post%0d_hi", i));
      step(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0),
           $sformatf("post%0d_lo", i));
    end
    step(mk(0, 0, 8'h00, 1, 4, 0, 8'h00, 6'h00, 0, 0, 0), "post_rd");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
